// File: rtl/efi_pkg.sv
// rtl/efi_pkg.sv - shared types and defaults for the crank VR front end
// Contents: vr_state_t (IDLE/FIRST/RUN), PERIOD_W, DEFAULT_TIMEOUT
package efi_pkg;

  localparam int PERIOD_W        = 32;
  localparam int DEFAULT_TIMEOUT = 2000000;

  // IDLE: no tooth yet, FIRST: one tooth seen, RUN: tooth period known
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RUN   = 2'd2
  } vr_state_t;

endpackage

// File: rtl/glitch_filter.sv
// rtl/glitch_filter.sv - 2-FF synchronizer plus stability filter for the raw VR input
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   din      : asynchronous raw comparator level
//   level    : filtered level
//   rise     : one-cycle strobe after a filtered 0->1 change
//   fall     : one-cycle strobe after a filtered 1->0 change
module glitch_filter
#(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       sync1;
  logic       sync2;
  logic [7:0] count;
  logic       level_d;
  logic       armed;

  // Synchronizer carries no reset so it always reflects the pin.
  always_ff @(posedge clk) begin
    sync1 <= din;
    sync2 <= sync1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      armed   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      level_d <= level;
      // A level that was already high when reset released must go low
      // before its rise counts, so rising strobes wait for a low sample.
      rise    <= level & ~level_d & armed;
      fall    <= ~level & level_d;
      if (!sync2 && !level) begin
        armed <= 1'b1;
      end
      if (sync2 == level) begin
        count <= '0;
      end else if (count == 8'(FILT_LEN - 1)) begin
        level <= ~level;
        count <= '0;
      end else begin
        count <= count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/vr_conditioner.sv
// rtl/vr_conditioner.sv - crank VR conditioner: glitch filter, adaptive blanking, period and stall status
// Ports:
//   clk, rst     : EFI clock, synchronous active-high reset
//   vr_raw       : asynchronous raw comparator output
//   en           : enable; low holds the block idle (reject_cnt holds)
//   vr_clean     : cleaned tooth level for the synchronizer
//   tooth_edge   : one-cycle pulse per accepted rising edge
//   period       : cycles between the last two accepted edges
//   period_valid : period holds a real measurement
//   stalled      : no accepted edge within TIMEOUT, or not started
//   reject_cnt   : saturating count of blanked rising edges
module vr_conditioner
#(
  parameter int FILT_LEN    = 8,
  parameter int BLANK_SHIFT = 2,
  parameter int TIMEOUT     = efi_pkg::DEFAULT_TIMEOUT,
  parameter int PERIOD_W    = efi_pkg::PERIOD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vr_raw,
  input  logic                en,
  output logic                vr_clean,
  output logic                tooth_edge,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stalled,
  output logic [15:0]         reject_cnt
);
  import efi_pkg::*;

  localparam logic [PERIOD_W-1:0] TIMEOUT_CNT = PERIOD_W'(TIMEOUT);

  vr_state_t           state;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] blank;
  logic                filt_level;
  logic                cand_rise;
  logic                cand_fall;
  logic                accept;
  logic                reject;
  logic                timeout;

  glitch_filter #(
    .FILT_LEN(FILT_LEN)
  ) u_filter (
    .clk  (clk),
    .rst  (rst),
    .din  (vr_raw),
    .level(filt_level),
    .rise (cand_rise),
    .fall (cand_fall)
  );

  assign blank = period >> BLANK_SHIFT;

  // A candidate on the timeout cycle takes priority over the stall.
  always_comb begin
    accept  = 1'b0;
    reject  = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE:  accept = cand_rise;
      FIRST: begin
        accept  = cand_rise;
        timeout = !cand_rise && (cnt == TIMEOUT_CNT);
      end
      RUN: begin
        accept  = cand_rise && (cnt >= blank);
        reject  = cand_rise && (cnt < blank);
        timeout = !cand_rise && (cnt == TIMEOUT_CNT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state        <= IDLE;
      cnt          <= '0;
      vr_clean     <= 1'b0;
      tooth_edge   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b1;
      if (rst) begin
        reject_cnt <= '0;
      end
    end else begin
      tooth_edge <= accept;
      if (accept) begin
        cnt      <= PERIOD_W'(1);
        vr_clean <= 1'b1;
      end else begin
        if (cnt != '1) begin
          cnt <= cnt + PERIOD_W'(1);
        end
        if (cand_fall) begin
          vr_clean <= 1'b0;
        end
      end
      if (reject && reject_cnt != 16'hFFFF) begin
        reject_cnt <= reject_cnt + 16'd1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= FIRST;
            stalled <= 1'b0;
          end
        end
        FIRST: begin
          if (accept) begin
            state        <= RUN;
            period       <= cnt;
            period_valid <= 1'b1;
          end else if (timeout) begin
            state        <= IDLE;
            stalled      <= 1'b1;
            period_valid <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            period <= cnt;
          end else if (timeout) begin
            state        <= IDLE;
            stalled      <= 1'b1;
            period_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vr_conditioner.md
Name: vr_conditioner

Overview:
- Front-end conditioner for the raw crank VR comparator output.
- Sits directly upstream of the synchronizer and drives its `vrin` input with one clean, glitch-free level per tooth.
- Rejects noise by two mechanisms:
  - a stability (glitch) filter;
  - an adaptive blanking window derived from the last accepted tooth period.
- Also reports tooth period, stall status and a rejected-edge count, which firmware reads as SPI status.

Parameters:
- `FILT_LEN`, 8: consecutive identical samples required before the filtered level changes (1..255).
- `BLANK_SHIFT`, 2: blanking window = `last_period >> BLANK_SHIFT` cycles after an accepted edge.
- `TIMEOUT`, 2000000: cycles without an accepted edge before declaring a stall.
- `PERIOD_W`, 32: width of the period counter and period output.

Ports:
- `clk` in 1: EFI clock.
- `rst` in 1: synchronous, active-high reset.
- `vr_raw` in 1: asynchronous raw comparator output.
- `en` in 1: conditioner enable; low holds the block idle.
- `vr_clean` out 1: cleaned tooth level, feeds synchronizer `vrin`.
- `tooth_edge` out 1: one-cycle pulse on each accepted rising edge.
- `period` out PERIOD_W: clk cycles between the last two accepted edges.
- `period_valid` out 1: `period` holds a real measurement.
- `stalled` out 1: no accepted edge within `TIMEOUT`, or not yet started.
- `reject_cnt` out 16: saturating count of blanked (rejected) rising edges.

Behaviour:
- **Clock and reset.**
  - One clock; reset is synchronous and active-high (`clk`, `rst`).
  - Reset values: `vr_clean`=0, `tooth_edge`=0, `period`=0, `period_valid`=0, `stalled`=1, `reject_cnt`=0.
  - Internal state on reset: filter count 0, filtered level 0, `cnt`=0, state IDLE.
- **Input synchronizer.** `vr_raw` passes through a 2-FF synchronizer; the synchronizer is not reset-dependent.
- **Glitch filter.**
  - A counter increments while the synchronized sample differs from the filtered level.
  - The counter clears to 0 on any sample equal to the filtered level.
  - When the counter reaches `FILT_LEN`, the filtered level toggles and the counter clears.
  - Any pulse shorter than `FILT_LEN` cycles is fully suppressed.
- **Candidate edge.** A 0->1 transition of the filtered level.
- **`cnt`.** Saturating PERIOD_W counter of cycles since the last accepted edge.
  - Set to 1 on an accepting cycle, otherwise increments.
  - Stops incrementing at all-ones.
- **FSM states.** IDLE (no edge), FIRST (one edge, no period yet), RUN (period known).
  - IDLE + candidate -> FIRST: accept, `cnt`<=1, `stalled`<=0.
  - FIRST + candidate -> RUN: accept, `period`<=`cnt`, `period_valid`<=1.
  - RUN + candidate:
    - If `cnt` >= (`period` >> `BLANK_SHIFT`): accept, `period`<=`cnt`.
    - Otherwise reject: `reject_cnt`++ (saturating at 16'hFFFF); `vr_clean`, `tooth_edge`, `cnt` and `period` are unaffected.
  - FIRST/RUN with no candidate and `cnt` == `TIMEOUT` -> IDLE: `stalled`<=1, `period_valid`<=0, `period` holds its last value.
  - A candidate in the same cycle as `cnt` == `TIMEOUT` wins and is accepted normally, with no stall.
- **On every accept:**
  - `tooth_edge`=1 for exactly one cycle.
  - `vr_clean`<=1.
- **Falling edge.** `vr_clean`<=0 on the filtered 1->0 transition.
  - A rejected tooth therefore never raises `vr_clean`.
  - The falling edge of a rejected tooth is ignored.
- **Latency.** From the first clk edge at which `vr_raw` is high and then stays high, `tooth_edge`/`vr_clean` assert `FILT_LEN`+3 cycles later. The same latency applies to the falling edge of `vr_clean`.
- **`en` low.**
  - Forces IDLE on the next cycle.
  - Outputs take their reset values, except `reject_cnt`, which holds.
  - The glitch filter keeps tracking.
- **Reset mid-tooth.** `vr_clean` drops the cycle after `rst`. A level still high after reset is not a candidate until it falls and rises again.

Decomposition:
- Package `efi_pkg`:
  - the FSM state enum (IDLE/FIRST/RUN);
  - `PERIOD_W`;
  - the default `TIMEOUT`.
- Sub-module `glitch_filter`:
  - contains the 2-FF synchronizer plus the stability counter;
  - exposes the filtered level and the rise/fall strobes.
- `vr_conditioner` contains the FSM, `cnt`, blanking and status logic.

Test Plan:
- **Clean teeth.** `FILT_LEN`=8; square wave on `vr_raw`, period 1000 cycles, 50% duty.
  - First `tooth_edge` 11 cycles after the first rise.
  - Then `period`=1000, `period_valid`=1 after the second edge, `stalled`=0.
- **Glitches.** 5-cycle high pulses between teeth -> no change on `vr_clean`, `reject_cnt` stays 0.
- **Blanking.** `period`=1000, `BLANK_SHIFT`=2.
  - Clean 20-cycle pulse rising 200 cycles after a tooth -> rejected, `reject_cnt`=1, `period` stays 1000.
  - Same pulse at 260 cycles -> accepted, `period`=260.
- **Stall.** `TIMEOUT`=5000; stop input after a tooth.
  - `stalled`=1 and `period_valid`=0 exactly 5000 cycles after the last accept; state IDLE.
  - Next tooth -> FIRST with no period update.
- **Boundary.** Candidate edge lands on the cycle with `cnt`==`TIMEOUT` -> accepted, `period`=`TIMEOUT`, `stalled` stays 0.
- **Reset / enable.**
  - Assert `rst` mid-tooth -> all outputs at reset values next cycle.
  - Drop `en` with `reject_cnt`=3 -> IDLE, `reject_cnt` stays 3.
